// File: rtl/dynamic_sum_serializer.sv
// Serialises one adjusted_sum word, LSB first, with a frame length of 9, 10 or 11 bits set by the size code.
// Optional macro SER_PARITY_EN appends one even-parity beat to every frame.
module dynamic_sum_serializer #(
  parameter int unsigned SUM_W = 11,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [SUM_W-1:0] sum_i,
  input  logic [1:0]       size_i,
  output logic             ser_out_o,
  output logic             ser_valid_o,
  output logic             ser_last_o,
  input  logic             ser_ready_i,
  output logic             busy_o
);

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  state_e           state_q;
  logic [SUM_W-2:0] shreg_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ser_out_q;
  logic             ser_valid_q;
  logic             ser_last_q;
  logic             busy_q;
  logic             in_ready_q;

  logic [CNT_W-1:0] nbits_d;
  logic [CNT_W-1:0] frame_d;
  logic [SUM_W-1:0] mask_d;
  logic [SUM_W-1:0] cap_d;
  logic             next_bit_d;

`ifdef SER_PARITY_EN
  logic             par_q;
`endif

  // Capture path: frame width from the size code, upper bits masked off.
  always_comb begin
    nbits_d = CNT_W'(11);
    if (size_i == 2'b00)      nbits_d = CNT_W'(9);
    else if (size_i == 2'b01) nbits_d = CNT_W'(10);
`ifdef SER_PARITY_EN
    frame_d = nbits_d + CNT_W'(1);
`else
    frame_d = nbits_d;
`endif
    mask_d = '0;
    for (int i = 0; i < int'(SUM_W); i++) begin
      mask_d[i] = (i < int'(nbits_d));
    end
    cap_d = sum_i & mask_d;
  end

  // Bit presented after the current beat; the parity beat follows the last data bit.
  always_comb begin
`ifdef SER_PARITY_EN
    next_bit_d = (cnt_q == CNT_W'(2)) ? par_q : shreg_q[0];
`else
    next_bit_d = shreg_q[0];
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef SER_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            // Bit 0 goes straight to the output register; the rest wait in shreg_q.
            state_q     <= S_SHIFT;
            shreg_q     <= cap_d[SUM_W-1:1];
            cnt_q       <= frame_d;
            ser_out_q   <= cap_d[0];
            ser_valid_q <= 1'b1;
            ser_last_q  <= 1'b0;
            busy_q      <= 1'b1;
            in_ready_q  <= 1'b0;
`ifdef SER_PARITY_EN
            par_q       <= ^cap_d;
`endif
          end
        end
        S_SHIFT: begin
          if (ser_ready_i) begin
            shreg_q <= shreg_q >> 1;
            cnt_q   <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q     <= S_IDLE;
              ser_out_q   <= 1'b0;
              ser_valid_q <= 1'b0;
              ser_last_q  <= 1'b0;
              busy_q      <= 1'b0;
              in_ready_q  <= 1'b1;
            end else begin
              ser_out_q  <= next_bit_d;
              ser_last_q <= (cnt_q == CNT_W'(2));
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign ser_out_o   = ser_out_q;
  assign ser_valid_o = ser_valid_q;
  assign ser_last_o  = ser_last_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_dynamic_sum_serializer.sv
// Bench for dynamic_sum_serializer: directed frames plus random traffic against a bit-queue reference model.
// Honours SER_PARITY_EN the same way the design does.
module tb_dynamic_sum_serializer;

  localparam int unsigned SUM_W = 11;
  localparam int unsigned CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [SUM_W-1:0] sum_i;
  logic [1:0]       size_i;
  logic             ser_out_o;
  logic             ser_valid_o;
  logic             ser_last_o;
  logic             ser_ready_i;
  logic             busy_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  bit          exp_q[$];

  dynamic_sum_serializer #(.SUM_W(SUM_W), .CNT_W(CNT_W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .sum_i       (sum_i),
    .size_i      (size_i),
    .ser_out_o   (ser_out_o),
    .ser_valid_o (ser_valid_o),
    .ser_last_o  (ser_last_o),
    .ser_ready_i (ser_ready_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the beats a word should produce, in transmit order.
  task automatic load_frame(input logic [SUM_W-1:0] w, input logic [1:0] z);
    int nb;
    bit par;
    nb  = (z == 2'd0) ? 9 : (z == 2'd1) ? 10 : 11;
    par = 1'b0;
    for (int i = 0; i < nb; i++) begin
      exp_q.push_back(w[i]);
      par ^= w[i];
    end
`ifdef SER_PARITY_EN
    exp_q.push_back(par);
`endif
  endtask

  // One cycle: check outputs against the model, drive inputs, advance the model past the next edge.
  task automatic step(input logic v, input logic [SUM_W-1:0] s, input logic [1:0] z, input logic r);
    bit act;
    act = (exp_q.size() != 0);
    check_eq("busy", busy_o, act);
    check_eq("ser_valid", ser_valid_o, act);
    check_eq("in_ready", in_ready_o, !act);
    if (act) begin
      check_eq("ser_out", ser_out_o, exp_q[0]);
      check_eq("ser_last", ser_last_o, exp_q.size() == 1);
    end
    in_valid_i  = v;
    sum_i       = s;
    size_i      = z;
    ser_ready_i = r;
    if (act && r) void'(exp_q.pop_front());
    else if (!act && v) load_frame(s, z);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(1'b0, '0, 2'd0, 1'b1);
    step(1'b0, '0, 2'd0, 1'b1);
  endtask

  initial begin
    rst_i = 1'b1; in_valid_i = 1'b0; sum_i = '0; size_i = '0; ser_ready_i = 1'b0;
    #2;
    check_eq("rst_in_ready", in_ready_o, 1'b1);
    check_eq("rst_ser_valid", ser_valid_o, 1'b0);
    check_eq("rst_ser_out", ser_out_o, 1'b0);
    check_eq("rst_ser_last", ser_last_o, 1'b0);
    check_eq("rst_busy", busy_o, 1'b0);
    @(posedge clk_i); @(negedge clk_i);
    rst_i = 1'b0;

    // Full 11-bit frame, then a 9-bit frame that drops bits 10:9.
    step(1'b1, 11'h4FE, 2'd2, 1'b1);
    drain();
    step(1'b1, 11'h7FE, 2'd0, 1'b1);
    drain();
    step(1'b1, 11'h2AA, 2'd3, 1'b1);
    drain();

    // Stall for three cycles after beat 4.
    step(1'b1, 11'h4FE, 2'd2, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 2'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 2'd0, 1'b0);
      check_eq("stall_out", ser_out_o, 1'b1);
      check_eq("stall_last", ser_last_o, 1'b0);
    end
    drain();

    // in_valid during a frame must be ignored until in_ready returns.
    step(1'b1, 11'h4FE, 2'd2, 1'b1);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(1'b1, 11'h123, 2'd1, 1'b1);
    step(1'b1, 11'h123, 2'd1, 1'b1);
    drain();

    // Asynchronous reset mid-frame, then a fresh frame from bit 0.
    step(1'b1, 11'h4FE, 2'd2, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 2'd0, 1'b1);
    rst_i = 1'b1;
    #1;
    check_eq("arst_ser_valid", ser_valid_o, 1'b0);
    check_eq("arst_busy", busy_o, 1'b0);
    check_eq("arst_in_ready", in_ready_o, 1'b1);
    exp_q.delete();
    in_valid_i = 1'b0;
    @(posedge clk_i); @(negedge clk_i);
    rst_i = 1'b0;
    step(1'b1, 11'h0B5, 2'd1, 1'b1);
    drain();

`ifdef SER_PARITY_EN
    step(1'b1, 11'h007, 2'd0, 1'b1);
    drain();
`endif

    // Random traffic with random backpressure and sizes.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 3) != 0, SUM_W'($urandom), 2'($urandom), ($urandom % 4) != 0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
